key_event_gen: RTL and testbench

//  Downstream of the key debouncer. Takes the debounced active-low key level and turns it into

---
 rtl/key_event_gen_if.sv | 20 ++
 rtl/key_event_gen.sv | 105 ++++++++++
 tb/tb_key_event_gen.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/key_event_gen_if.sv
// Key event bundle: debounced key level in, event pulses, held flag and press count out.
`timescale 1ns/1ps
interface key_event_gen_if;
  logic       key_in;
  logic       press_pulse;
  logic       rel_pulse;
  logic       long_pulse;
  logic       rpt_pulse;
  logic       key_held;
  logic [7:0] press_cnt;

  modport master (
    output key_in,
    input  press_pulse, rel_pulse, long_pulse, rpt_pulse, key_held, press_cnt
  );
  modport slave (
    input  key_in,
    output press_pulse, rel_pulse, long_pulse, rpt_pulse, key_held, press_cnt
  );
endinterface

// File: rtl/key_event_gen.sv
// Turns a debounced active-low key level into press/release/long/repeat pulses,
// a held flag and a wrapping press counter. Every output is registered.
`timescale 1ns/1ps
module key_event_gen #(
  parameter int LONG_CNT   = 25_000_000,
  parameter int REPEAT_CNT = 5_000_000,
  parameter int CNT_W      = 25
) (
  input  logic           sys_clk,
  input  logic           sys_rst_n,
  key_event_gen_if.slave kif
);
  typedef enum logic [1:0] {IDLE = 2'd0, PRESS = 2'd1, LONG = 2'd2} state_t;

  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CNT - 1);
  localparam logic [CNT_W-1:0] RPT_LAST  = CNT_W'(REPEAT_CNT - 1);

  state_t           state, nxt_state;
  logic [CNT_W-1:0] cnt, nxt_cnt;
  logic             key_d1;
  logic [7:0]       pcnt, nxt_pcnt;
  logic             press_q, rel_q, long_q, rpt_q, held_q;
  logic             nxt_press, nxt_rel, nxt_long, nxt_rpt;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      key_d1  <= 1'b0;
      pcnt    <= '0;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
      long_q  <= 1'b0;
      rpt_q   <= 1'b0;
      held_q  <= 1'b0;
    end else begin
      state   <= nxt_state;
      cnt     <= nxt_cnt;
      key_d1  <= kif.key_in;
      pcnt    <= nxt_pcnt;
      press_q <= nxt_press;
      rel_q   <= nxt_rel;
      long_q  <= nxt_long;
      rpt_q   <= nxt_rpt;
      held_q  <= (nxt_state != IDLE);
    end
  end

  // Release is tested first in PRESS/LONG so it wins over long/repeat on the same edge.
  always_comb begin
    nxt_state = state;
    nxt_cnt   = cnt;
    nxt_pcnt  = pcnt;
    nxt_press = 1'b0;
    nxt_rel   = 1'b0;
    nxt_long  = 1'b0;
    nxt_rpt   = 1'b0;
    case (state)
      IDLE: begin
        if (key_d1 && !kif.key_in) begin
          nxt_state = PRESS;
          nxt_cnt   = '0;
          nxt_press = 1'b1;
          nxt_pcnt  = pcnt + 8'd1;
        end
      end
      PRESS: begin
        if (kif.key_in) begin
          nxt_rel   = 1'b1;
          nxt_state = IDLE;
          nxt_cnt   = '0;
        end else if (cnt == LONG_LAST) begin
          nxt_long  = 1'b1;
          nxt_state = LONG;
          nxt_cnt   = '0;
        end else begin
          nxt_cnt   = cnt + CNT_W'(1);
        end
      end
      LONG: begin
        if (kif.key_in) begin
          nxt_rel   = 1'b1;
          nxt_state = IDLE;
          nxt_cnt   = '0;
        end else if (cnt == RPT_LAST) begin
          nxt_rpt   = 1'b1;
          nxt_cnt   = '0;
        end else begin
          nxt_cnt   = cnt + CNT_W'(1);
        end
      end
      default: begin
        nxt_state = IDLE;
        nxt_cnt   = '0;
      end
    endcase
  end

  assign kif.press_pulse = press_q;
  assign kif.rel_pulse   = rel_q;
  assign kif.long_pulse  = long_q;
  assign kif.rpt_pulse   = rpt_q;
  assign kif.key_held    = held_q;
  assign kif.press_cnt   = pcnt;
endmodule

// File: tb/tb_key_event_gen.sv
// Bench for key_event_gen: expected pulse events queued at stimulus time, observed events
// queued by a monitor, both drained and compared at the end of each scenario.
`timescale 1ns/1ps
module tb_key_event_gen;
  localparam int LONG = 8;
  localparam int REP  = 4;

  logic sys_clk   = 1'b0;
  logic sys_rst_n = 1'b0;
  key_event_gen_if kif ();

  key_event_gen #(.LONG_CNT(LONG), .REPEAT_CNT(REP), .CNT_W(4)) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .kif       (kif)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {int kind; int edge_n;} ev_t;
  ev_t   exp_q[$];
  ev_t   obs_q[$];
  int    cyc = 0;
  int    n_chk = 0;
  int    n_fail = 0;
  string kname[4] = '{"press", "rel", "long", "rpt"};

  always @(posedge sys_clk) cyc <= cyc + 1;

  // cyc at a negedge is the number of the posedge that registered the visible pulse
  always @(negedge sys_clk) begin
    logic [3:0] p;
    p = {kif.rpt_pulse, kif.long_pulse, kif.rel_pulse, kif.press_pulse};
    for (int k = 0; k < 4; k++)
      if (p[k]) obs_q.push_back('{k, cyc});
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached at cycle %0d, required finish before", cyc);
    $fatal(1, "watchdog");
  end

  task automatic push_ev(input int kind, input int e);
    exp_q.push_back('{kind, e});
  endtask

  // Drives key_in just after a posedge; e is the edge that samples it.
  task automatic drive_key(input logic v, output int e);
    @(posedge sys_clk);
    #1;
    kif.key_in = v;
    e = cyc + 1;
  endtask

  // Press held for h sampled edges, then released; expectations from the timing rules.
  task automatic press_hold(input int h);
    int n, r;
    drive_key(1'b0, n);
    push_ev(0, n);
    if (h >= LONG + 1) begin
      push_ev(2, n + LONG);
      for (int t = n + LONG + REP; t < n + h; t += REP) push_ev(3, t);
    end
    repeat (h - 1) @(posedge sys_clk);
    drive_key(1'b1, r);
    push_ev(1, r);
  endtask

  task automatic test_reset();
    sys_rst_n  = 1'b0;
    kif.key_in = 1'b1;
    repeat (3) @(posedge sys_clk);
    #1;
    n_chk++;
    if ({kif.press_pulse, kif.rel_pulse, kif.long_pulse, kif.rpt_pulse, kif.key_held, kif.press_cnt} !== 13'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b, required all zero",
        {kif.press_pulse, kif.rel_pulse, kif.long_pulse, kif.rpt_pulse, kif.key_held, kif.press_cnt});
    end
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    @(posedge sys_clk);
  endtask

  task automatic test_short_press();
    int n;
    ev_t e, o;
    drive_key(1'b0, n);
    push_ev(0, n);
    for (int i = 0; i < 3; i++) begin
      @(posedge sys_clk);
      @(negedge sys_clk);
      n_chk++;
      if (kif.key_held !== 1'b1) begin
        n_fail++;
        $display("FAIL t1_held: key_held=%b after edge %0d, required 1", kif.key_held, cyc);
      end
    end
    kif.key_in = 1'b1;
    push_ev(1, n + 3);
    @(posedge sys_clk);
    @(negedge sys_clk);
    n_chk++;
    if (kif.key_held !== 1'b0) begin
      n_fail++;
      $display("FAIL t1_held_drop: key_held=%b after release, required 0", kif.key_held);
    end
    n_chk++;
    if (kif.press_cnt !== 8'd1) begin
      n_fail++;
      $display("FAIL t1_press_cnt: got %0d, required 1", kif.press_cnt);
    end
    repeat (3) @(negedge sys_clk);
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_chk++;
      if (o.kind !== e.kind || o.edge_n !== e.edge_n) begin
        n_fail++;
        $display("FAIL t1_event: got %s@%0d, required %s@%0d", kname[o.kind], o.edge_n, kname[e.kind], e.edge_n);
      end
    end
    n_chk++;
    if (exp_q.size() != 0 || obs_q.size() != 0) begin
      n_fail++;
      $display("FAIL t1_leftover: %0d expected unseen, %0d unexpected, required 0/0", exp_q.size(), obs_q.size());
      exp_q.delete(); obs_q.delete();
    end
  endtask

  task automatic test_long_repeat();
    ev_t e, o;
    press_hold(20);
    repeat (4) @(negedge sys_clk);
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_chk++;
      if (o.kind !== e.kind || o.edge_n !== e.edge_n) begin
        n_fail++;
        $display("FAIL t2_event: got %s@%0d, required %s@%0d", kname[o.kind], o.edge_n, kname[e.kind], e.edge_n);
      end
    end
    n_chk++;
    if (exp_q.size() != 0 || obs_q.size() != 0) begin
      n_fail++;
      $display("FAIL t2_leftover: %0d expected unseen, %0d unexpected, required 0/0", exp_q.size(), obs_q.size());
      exp_q.delete(); obs_q.delete();
    end
    n_chk++;
    if (kif.press_cnt !== 8'd2 || kif.key_held !== 1'b0) begin
      n_fail++;
      $display("FAIL t2_state: press_cnt=%0d held=%b, required 2/0", kif.press_cnt, kif.key_held);
    end
  endtask

  task automatic test_threshold_race();
    ev_t e, o;
    press_hold(LONG);
    repeat (4) @(negedge sys_clk);
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_chk++;
      if (o.kind !== e.kind || o.edge_n !== e.edge_n) begin
        n_fail++;
        $display("FAIL t3_event: got %s@%0d, required %s@%0d", kname[o.kind], o.edge_n, kname[e.kind], e.edge_n);
      end
    end
    n_chk++;
    if (exp_q.size() != 0 || obs_q.size() != 0) begin
      n_fail++;
      $display("FAIL t3_leftover: %0d expected unseen, %0d unexpected, required 0/0", exp_q.size(), obs_q.size());
      exp_q.delete(); obs_q.delete();
    end
  endtask

  task automatic test_held_through_reset();
    int r;
    ev_t e, o;
    @(negedge sys_clk);
    sys_rst_n  = 1'b0;
    kif.key_in = 1'b0;
    repeat (2) @(negedge sys_clk);
    n_chk++;
    if (kif.press_cnt !== 8'd0 || kif.key_held !== 1'b0) begin
      n_fail++;
      $display("FAIL t4_in_reset: press_cnt=%0d held=%b, required 0/0", kif.press_cnt, kif.key_held);
    end
    sys_rst_n = 1'b1;
    repeat (10) @(negedge sys_clk);
    n_chk++;
    if (kif.key_held !== 1'b0 || obs_q.size() != 0) begin
      n_fail++;
      $display("FAIL t4_no_events: held=%b events=%0d, required 0/0", kif.key_held, obs_q.size());
      obs_q.delete();
    end
    drive_key(1'b1, r);
    repeat (2) @(posedge sys_clk);
    press_hold(2);
    repeat (4) @(negedge sys_clk);
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_chk++;
      if (o.kind !== e.kind || o.edge_n !== e.edge_n) begin
        n_fail++;
        $display("FAIL t4_event: got %s@%0d, required %s@%0d", kname[o.kind], o.edge_n, kname[e.kind], e.edge_n);
      end
    end
    n_chk++;
    if (exp_q.size() != 0 || obs_q.size() != 0) begin
      n_fail++;
      $display("FAIL t4_leftover: %0d expected unseen, %0d unexpected, required 0/0", exp_q.size(), obs_q.size());
      exp_q.delete(); obs_q.delete();
    end
    n_chk++;
    if (kif.press_cnt !== 8'd1) begin
      n_fail++;
      $display("FAIL t4_press_cnt: got %0d, required 1", kif.press_cnt);
    end
  endtask

  task automatic test_reset_mid_long();
    int n;
    ev_t e, o;
    press_hold(2);
    drive_key(1'b0, n);
    push_ev(0, n);
    push_ev(2, n + LONG);
    repeat (LONG + 2) @(posedge sys_clk);
    #1;
    n_chk++;
    if (kif.key_held !== 1'b1 || kif.press_cnt !== 8'd3) begin
      n_fail++;
      $display("FAIL t5_in_long: held=%b press_cnt=%0d, required 1/3", kif.key_held, kif.press_cnt);
    end
    #2;
    sys_rst_n = 1'b0;
    #1;
    n_chk++;
    if ({kif.press_pulse, kif.rel_pulse, kif.long_pulse, kif.rpt_pulse, kif.key_held, kif.press_cnt} !== 13'd0) begin
      n_fail++;
      $display("FAIL t5_async_reset: got %b, required all zero",
        {kif.press_pulse, kif.rel_pulse, kif.long_pulse, kif.rpt_pulse, kif.key_held, kif.press_cnt});
    end
    kif.key_in = 1'b1;
    repeat (3) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    repeat (10) @(negedge sys_clk);
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_chk++;
      if (o.kind !== e.kind || o.edge_n !== e.edge_n) begin
        n_fail++;
        $display("FAIL t5_event: got %s@%0d, required %s@%0d", kname[o.kind], o.edge_n, kname[e.kind], e.edge_n);
      end
    end
    n_chk++;
    if (exp_q.size() != 0 || obs_q.size() != 0) begin
      n_fail++;
      $display("FAIL t5_leftover: %0d expected unseen, %0d unexpected, required 0/0", exp_q.size(), obs_q.size());
      exp_q.delete(); obs_q.delete();
    end
  endtask

  task automatic test_wrap();
    ev_t e, o;
    for (int i = 0; i < 256; i++) begin
      press_hold(2);
      if (i == 254) begin
        n_chk++;
        if (kif.press_cnt !== 8'd255) begin
          n_fail++;
          $display("FAIL t6_cnt_255: got %0d, required 255", kif.press_cnt);
        end
      end
    end
    repeat (4) @(negedge sys_clk);
    n_chk++;
    if (kif.press_cnt !== 8'd0) begin
      n_fail++;
      $display("FAIL t6_wrap: got %0d, required 0", kif.press_cnt);
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_chk++;
      if (o.kind !== e.kind || o.edge_n !== e.edge_n) begin
        n_fail++;
        $display("FAIL t6_event: got %s@%0d, required %s@%0d", kname[o.kind], o.edge_n, kname[e.kind], e.edge_n);
      end
    end
    n_chk++;
    if (exp_q.size() != 0 || obs_q.size() != 0) begin
      n_fail++;
      $display("FAIL t6_leftover: %0d expected unseen, %0d unexpected, required 0/0", exp_q.size(), obs_q.size());
      exp_q.delete(); obs_q.delete();
    end
  endtask

  initial begin
    kif.key_in = 1'b1;
    test_reset();
    obs_q.delete();
    test_short_press();
    test_long_repeat();
    test_threshold_race();
    test_held_through_reset();
    test_reset_mid_long();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
